// File: rtl/m_seq_pkg.sv
// m_seq_pkg: shared constants and state encoding for the 8-bit m-sequence blocks
package m_seq_pkg;
  localparam logic [7:0] POLY_TAPS = 8'b0111_0001;
  localparam int SEQ_LEN = 255;
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } state_e;
  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction
  localparam logic [7:0] REC_MASK = rev8(POLY_TAPS);
endpackage

// File: rtl/m_seq_8bit_pred.sv
// m_seq_8bit_pred: received-bit history and next-bit prediction from the recurrence
module m_seq_8bit_pred
  import m_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_i,
  input  logic       sel_pred_i,
  input  logic       rx_bit_i,
  output logic       pred_o,
  output logic [7:0] hist_shift_o
);
  logic [7:0] hist_q, hist_d;
  assign pred_o       = ^(hist_q & REC_MASK);
  assign hist_shift_o = {hist_q[6:0], sel_pred_i ? pred_o : rx_bit_i};
  // shift in either the received bit or the flywheel prediction
  always_comb hist_d = shift_i ? hist_shift_o : hist_q;
  // history register
  always_ff @(posedge clk)
    if (rst) hist_q <= '0;
    else hist_q <= hist_d;
endmodule

// File: rtl/m_seq_8bit_check.sv
// m_seq_8bit_check: lock, flywheel-check and error counting for the 8-bit m-sequence
module m_seq_8bit_check
  import m_seq_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_bit_i,
  input  logic        rx_valid_i,
  input  logic        clr_cnt_i,
  output logic        locked_o,
  output logic        err_pulse_o,
  output logic [15:0] err_cnt_o,
  output logic [31:0] bit_cnt_o
);
  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0] WIN_C  = 8'(LOSS_WIN);
  localparam logic [7:0] THR_C  = 8'(LOSS_THR);
  state_e      state_q, state_d;
  logic [3:0]  fill_q, fill_d;
  logic [7:0]  match_q, match_d, win_q, win_d, werr_q, werr_d, win_n, werr_n;
  logic [15:0] err_cnt_q, err_cnt_d, err_base;
  logic [31:0] bit_cnt_q, bit_cnt_d, bit_base;
  logic        locked_q, err_pulse_q, pred, err, count;
  logic [7:0]  hist_shift;

  m_seq_8bit_pred u_pred (
    .clk          (clk),
    .rst          (rst),
    .shift_i      (rx_valid_i),
    .sel_pred_i   (state_q == LOCKED),
    .rx_bit_i     (rx_bit_i),
    .pred_o       (pred),
    .hist_shift_o (hist_shift)
  );

  assign err    = rx_bit_i ^ pred;
  assign count  = rx_valid_i && state_q == LOCKED;
  assign win_n  = win_q + 8'd1;
  assign werr_n = werr_q + 8'(err);

  // lock FSM: fill, verify run of matches, then window-based loss detection
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    if (rx_valid_i)
      unique case (state_q)
        ACQUIRE: begin
          fill_d  = fill_q + 4'd1;
          state_d = fill_q == 4'd7 ? VERIFY : ACQUIRE;
          match_d = '0;
        end
        VERIFY: begin
          match_d = err || match_q + 8'd1 == LOCK_C ? '0 : match_q + 8'd1;
          state_d = !err && match_q + 8'd1 == LOCK_C && hist_shift != '0 ? LOCKED : VERIFY;
        end
        LOCKED: begin
          if (werr_n == THR_C) begin
            state_d = ACQUIRE;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            win_d  = win_n == WIN_C ? '0 : win_n;
            werr_d = win_n == WIN_C ? '0 : werr_n;
          end
        end
        default: state_d = ACQUIRE;
      endcase
  end

  // saturating counters; a clear takes effect before the bit of the same cycle is counted
  always_comb begin
    err_base  = clr_cnt_i ? '0 : err_cnt_q;
    bit_base  = clr_cnt_i ? '0 : bit_cnt_q;
    err_cnt_d = err_base + 16'(count && err && !(&err_base));
    bit_cnt_d = bit_base + 32'(count && !(&bit_base));
  end

  // state, counters and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= ACQUIRE;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      locked_q    <= state_d == LOCKED;
      err_pulse_q <= count && err;
    end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_cnt_o   = err_cnt_q;
  assign bit_cnt_o   = bit_cnt_q;
endmodule

// File: tb/tb_m_seq_8bit_check.sv
// tb_m_seq_8bit_check: directed checks of acquisition, flywheel error counting and loss of lock
module tb_m_seq_8bit_check;
  import m_seq_pkg::*;
  logic        clk = 0, rst = 1, rx_bit_i = 0, rx_valid_i = 0, clr_cnt_i = 0;
  logic        locked_o, err_pulse_o;
  logic [15:0] err_cnt_o;
  logic [31:0] bit_cnt_o;
  logic [7:0]  gen = 8'h01;
  int          checks = 0, errors = 0, pulses = 0, drops = 0;

  m_seq_8bit_check dut (
    .clk         (clk),
    .rst         (rst),
    .rx_bit_i    (rx_bit_i),
    .rx_valid_i  (rx_valid_i),
    .clr_cnt_i   (clr_cnt_i),
    .locked_o    (locked_o),
    .err_pulse_o (err_pulse_o),
    .err_cnt_o   (err_cnt_o),
    .bit_cnt_o   (bit_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic v, input logic c);
    @(negedge clk);
    rx_bit_i = b;
    rx_valid_i = v;
    clr_cnt_i = c;
    @(posedge clk);
    #1;
    pulses += int'(err_pulse_o);
  endtask

  task automatic gen_send(input logic inv, input logic c);
    logic b;
    b = gen[7];
    gen = {gen[6:0], 1'b0} ^ (gen[7] ? 8'h71 : 8'h00);
    drive(b ^ inv, 1'b1, c);
  endtask

  task automatic relock(input string tag);
    for (int j = 1; j <= 24; j++) begin
      gen_send(1'b0, 1'b0);
      if (j == 23) chk({tag, "_pre"}, 32'(locked_o), 0);
      if (j == 24) chk({tag, "_lock"}, 32'(locked_o), 1);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_pulse", 32'(err_pulse_o), 0);
    chk("rst_err", 32'(err_cnt_o), 0);
    chk("rst_bits", bit_cnt_o, 0);
    rst = 0;
    pulses = 0;
    for (int n = 1; n <= 1000; n++) begin
      gen_send(1'b0, 1'b0);
      if (n == 23) chk("acq_pre", 32'(locked_o), 0);
      if (n == 24) chk("acq_lock", 32'(locked_o), 1);
      if (n > 24 && !locked_o) drops++;
    end
    chk("clean_drops", 32'(drops), 0);
    chk("clean_pulses", 32'(pulses), 0);
    chk("clean_err", 32'(err_cnt_o), 0);
    chk("clean_bits", bit_cnt_o, 976);
    gen_send(1'b1, 1'b0);
    chk("single_pulse", 32'(err_pulse_o), 1);
    chk("single_err", 32'(err_cnt_o), 1);
    chk("single_locked", 32'(locked_o), 1);
    pulses = 0;
    for (int n = 0; n < 60; n++) gen_send(1'b0, 1'b0);
    chk("after_single_pulses", 32'(pulses), 0);
    chk("after_single_err", 32'(err_cnt_o), 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("clr_err", 32'(err_cnt_o), 0);
    chk("clr_bits", bit_cnt_o, 0);
    for (int k = 1; k <= 8; k++) begin
      gen_send(1'b1, 1'b0);
      chk("burst_pulse", 32'(err_pulse_o), 1);
      chk("burst_locked", 32'(locked_o), k < 8 ? 1 : 0);
    end
    chk("burst_err", 32'(err_cnt_o), 8);
    chk("burst_bits", bit_cnt_o, 8);
    relock("burst_relock");
    chk("relock_err", 32'(err_cnt_o), 8);
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      drive(1'($urandom), 1'b0, 1'b0);
      chk("gap_pulse", 32'(err_pulse_o), 0);
    end
    chk("gap_locked", 32'(locked_o), 1);
    for (int n = 0; n < 10; n++) gen_send(1'b0, 1'b0);
    chk("gap_resume_pulses", 32'(pulses), 0);
    chk("gap_resume_bits", bit_cnt_o, 18);
    rst = 1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 0;
    drops = 0;
    for (int n = 0; n < 2 * SEQ_LEN; n++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (locked_o) drops++;
    end
    chk("zero_never_lock", 32'(drops), 0);
    chk("zero_err", 32'(err_cnt_o), 0);
    rst = 1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 0;
    for (int j = 1; j <= 24; j++) begin
      drive(1'($urandom), 1'b0, 1'b0);
      drive(1'($urandom), 1'b0, 1'b0);
      gen_send(1'b0, 1'b0);
      if (j == 23) chk("sparse_pre", 32'(locked_o), 0);
      if (j == 24) chk("sparse_lock", 32'(locked_o), 1);
    end
    for (int n = 0; n < 2; n++) begin
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      gen_send(1'b0, 1'b0);
    end
    chk("sparse_bits", bit_cnt_o, 2);
    gen_send(1'b1, 1'b1);
    chk("clr_hit_err", 32'(err_cnt_o), 1);
    chk("clr_hit_bits", bit_cnt_o, 1);
    chk("clr_hit_pulse", 32'(err_pulse_o), 1);
    drive(1'b0, 1'b0, 1'b0);
    chk("sparse_gap_pulse", 32'(err_pulse_o), 0);
    for (int k = 0; k < 4; k++) begin
      gen_send(1'b0, 1'b0);
      gen_send(1'b0, 1'b0);
      gen_send(1'b1, 1'b0);
    end
    chk("pre_rst_err", 32'(err_cnt_o), 5);
    chk("pre_rst_locked", 32'(locked_o), 1);
    rst = 1;
    drive(1'b0, 1'b0, 1'b0);
    chk("mid_rst_locked", 32'(locked_o), 0);
    chk("mid_rst_err", 32'(err_cnt_o), 0);
    chk("mid_rst_bits", bit_cnt_o, 0);
    rst = 0;
    relock("rst_relock");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_seq_8bit_check.md
# m_seq_8bit_check

Serial checker for the 8-bit m-sequence (polynomial x^8+x^6+x^5+x^4+1, period 255) produced by the team's Galois LFSR generator, whose serial output is bit 7 of its register. The block sits at the receive end of a link or BER loopback. It acquires lock on the incoming bit stream from the recurrence alone, then predicts each bit with a flywheel. It counts errors and declares loss of lock when the error density is too high.

## Interface
- LOCK_CNT, 16, consecutive correct predictions required in VERIFY before lock (2..255)
- LOSS_WIN, 64, window length in valid bits for loss-of-lock evaluation (8..255)
- LOSS_THR, 8, errors within one window that force loss of lock (1..LOSS_WIN)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_bit  in  1  received sequence bit
- rx_valid  in  1  rx_bit qualifier; when low, no state changes except clr_cnt
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt
- locked  out  1  registered lock indication
- err_pulse  out  1  one-cycle pulse per mismatched bit while LOCKED
- err_cnt  out  16  saturating error count (LOCKED only)
- bit_cnt  out  32  saturating count of valid bits checked while LOCKED

## Operation
- History register hist[7:0]. hist[k] holds the bit received k+1 valid bits ago.
- Predicted bit: p = hist[1]^hist[2]^hist[3]^hist[7].
- The shift occurs only on rx_valid. The new hist[0] is rx_bit in ACQUIRE and VERIFY, and p in LOCKED (flywheel, so each channel error is counted once).
- FSM states:
  - ACQUIRE: shift rx_bit in and count fill bits 0..8. On the 8th valid bit, go to VERIFY with the match count cleared.
  - VERIFY: compare rx_bit with p on each valid bit.
    - Match: increment the match count.
    - Mismatch: clear the match count and stay in VERIFY.
    - When the match count reaches LOCK_CNT and hist != 0, go to LOCKED. The hist value checked is the value after the shift.
    - If hist == 0 when the match count reaches LOCK_CNT, clear the match count and stay in VERIFY. This rejects the all-zero stream, which is a false lock.
  - LOCKED: on each valid bit, err = rx_bit ^ p.
    - The window counter counts valid bits from 1 to LOSS_WIN. The window error counter counts errors within the window.
    - When the window error count reaches LOSS_THR, go to ACQUIRE, clearing the fill, window and match counts.
    - When the window counter reaches LOSS_WIN without hitting the threshold, clear both window counters.
- err_cnt and bit_cnt increment only in LOCKED on valid bits. Both saturate at all-ones and are never reset by loss of lock.
- clr_cnt in the same cycle as a counted bit: the clear wins, then that bit is counted, so err_cnt is 1 on error and bit_cnt is 1.

## Timing
- Reset values:
  - state = ACQUIRE, hist = 0, all internal counters = 0.
  - locked = 0, err_pulse = 0, err_cnt = 0, bit_cnt = 0.
- All outputs are registered and reflect the valid bit sampled on the previous rising edge.
- Minimum acquisition: locked rises on the edge that samples the (8+LOCK_CNT)-th consecutive clean valid bit, and is visible the following cycle. With defaults this is the 24th bit.
- err_pulse is high for exactly the one cycle after the erroneous bit is sampled. With rx_valid low it is 0.
- On loss of lock, locked falls in the same cycle in which the threshold-reaching error's err_pulse is high. That error is counted in err_cnt.
- Gaps in rx_valid of any length leave all state unchanged.
- rst mid-operation returns everything to the reset values on the next edge. No partial preservation.

## Structure
- A shared package m_seq_pkg holds:
  - POLY_TAPS = 8'b0111_0001 (Galois feedback mask, bits 0,4,5,6)
  - SEQ_LEN = 255
  - the FSM state encoding: ACQUIRE=2'd0, VERIFY=2'd1, LOCKED=2'd2
- One sub-module is natural: m_seq_8bit_pred.
  - Contents: the hist register plus the prediction XOR.
  - Inputs: shift enable and source select.
- The FSM and counters live in the top.

## Test plan
- Feed the generator output (seed 1, bit 7 per clock) continuously after reset. Required response: locked = 1 at the cycle after the 24th bit, and err_cnt stays 0 over 1000 bits, with bit_cnt = 976.
- Once locked, invert exactly one bit. Required response: a single err_pulse, err_cnt = 1, locked stays 1, and the following bits show no further errors.
- Once locked, invert 8 bits within 64. Required response: locked falls with the 8th err_pulse, err_cnt = 8, and relock occurs 24 bits later.
- Drive a constant rx_bit = 0 for 500 valid bits. Required response: locked never asserts, and err_cnt = 0.
- Toggle rx_valid 1-of-3 with the generator stepping only on valid, and pulse clr_cnt in the same cycle as an injected error. Required response: lock at the 24th valid bit, and after the clear err_cnt = 1 and bit_cnt = 1.
- Assert rst while locked with err_cnt = 5. Required response: the next cycle shows locked = 0 and err_cnt = 0, and lock is reacquired 24 valid bits after rst deasserts.
